// File: rtl/if_stage_cached.sv
// MIPS instruction-fetch stage: PC register, branch redirect, direct-mapped
// one-word-per-line instruction cache with a req/ack refill FSM and IF/ID register.
module if_stage_cached #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INSN_W = 32,
    parameter int unsigned LINES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pcsrc,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              id_stall,
    input  logic              cache_inv,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INSN_W-1:0] mem_data,
    output logic              if_valid,
    output logic [INSN_W-1:0] if_insn,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic {RUN, MISS} state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] pc, pc_plus4, target_aligned, pend_target, redirect_pc;
    logic              pend_redirect, inv_pend;
    logic [IDX_W-1:0]  idx, fill_idx;
    logic [TAG_W-1:0]  tag, fill_tag;
    logic              hit;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_ram  [LINES];
    logic [INSN_W-1:0] data_ram [LINES];

    logic do_redirect, do_issue, do_miss, do_fill, fill_redirect;
    logic latch_pend, latch_inv, flush_if, inv_all;

    assign pc_plus4       = pc + ADDR_W'(4);
    assign target_aligned = branch_target & ~ADDR_W'(3);
    assign redirect_pc    = pcsrc ? target_aligned : pend_target;

    assign idx      = pc[IDX_W+1:2];
    assign tag      = pc[ADDR_W-1:IDX_W+2];
    assign fill_idx = mem_addr[IDX_W+1:2];
    assign fill_tag = mem_addr[ADDR_W-1:IDX_W+2];
    assign hit      = valid[idx] && (tag_ram[idx] == tag);

    assign busy = (state == MISS);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= RUN;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (!pcsrc && !id_stall && !hit) next_state = MISS;
            MISS:    if (mem_ack) next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // A redirect or invalidate seen during a refill is deferred to the ack edge,
    // so the outstanding request is always completed and its line written.
    always_comb begin
        do_redirect   = 1'b0;
        do_issue      = 1'b0;
        do_miss       = 1'b0;
        do_fill       = 1'b0;
        fill_redirect = 1'b0;
        latch_pend    = 1'b0;
        latch_inv     = 1'b0;
        flush_if      = 1'b0;
        inv_all       = 1'b0;
        case (state)
            RUN: begin
                inv_all = cache_inv;
                if (pcsrc) begin
                    do_redirect = 1'b1;
                    flush_if    = 1'b1;
                end else if (!id_stall) begin
                    if (hit) begin
                        do_issue = 1'b1;
                    end else begin
                        do_miss  = 1'b1;
                        flush_if = 1'b1;
                    end
                end
            end
            MISS: begin
                flush_if = !id_stall;
                if (mem_ack) begin
                    do_fill       = 1'b1;
                    fill_redirect = pend_redirect || pcsrc;
                    inv_all       = inv_pend || cache_inv;
                end else begin
                    latch_pend = pcsrc;
                    latch_inv  = cache_inv;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc            <= RESET_PC;
            pend_target   <= '0;
            pend_redirect <= 1'b0;
            inv_pend      <= 1'b0;
        end else begin
            if (do_redirect)        pc <= target_aligned;
            else if (do_issue)      pc <= pc_plus4;
            else if (fill_redirect) pc <= redirect_pc;

            if (latch_pend) begin
                pend_redirect <= 1'b1;
                pend_target   <= target_aligned;
            end else if (do_fill) begin
                pend_redirect <= 1'b0;
            end

            if (latch_inv)    inv_pend <= 1'b1;
            else if (do_fill) inv_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else if (do_miss) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
        end else if (do_fill) begin
            mem_req  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if_valid <= 1'b0;
            if_insn  <= '0;
            if_pc    <= '0;
            if_pc4   <= '0;
        end else if (do_issue) begin
            if_valid <= 1'b1;
            if_insn  <= data_ram[idx];
            if_pc    <= pc;
            if_pc4   <= pc_plus4;
        end else if (flush_if) begin
            if_valid <= 1'b0;
        end
    end

    // Invalidate takes precedence so a line filled under a pending invalidate stays invalid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        valid <= '0;
        else if (inv_all) valid <= '0;
        else if (do_fill) valid[fill_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_fill) begin
            tag_ram[fill_idx]  <= fill_tag;
            data_ram[fill_idx] <= mem_data;
        end
    end

endmodule

// File: doc/if_stage_cached.md
Name: if_stage_cached

Overview:
- Parametrised instruction-fetch stage for the MIPS pipeline.
- Contains the PC register, PC+4 incrementer and branch-redirect select.
- Contains a direct-mapped one-word-per-line instruction cache, with a refill state machine that talks to instruction memory over a req/ack handshake.
- Drives the IF/ID pipeline register (valid, instruction, PC, PC+4) and honours decode-stage stall and branch redirect.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- INSN_W, 32, instruction word width.
- LINES, 16, cache lines; power of two, >=2.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- pcsrc  in  1  branch/jump taken; redirect fetch.
- branch_target  in  ADDR_W  redirect address.
- id_stall  in  1  decode cannot accept; hold IF/ID outputs.
- cache_inv  in  1  invalidate all cache lines.
- mem_req  out  1  refill request.
- mem_addr  out  ADDR_W  refill word address.
- mem_ack  in  1  refill data valid this cycle.
- mem_data  in  INSN_W  refill word.
- if_valid  out  1  IF/ID register holds a real instruction.
- if_insn  out  INSN_W  fetched instruction.
- if_pc  out  ADDR_W  address of if_insn.
- if_pc4  out  ADDR_W  if_pc+4.
- busy  out  1  refill in progress (state != RUN).

Behaviour:
- Reset (async, rstn=0) values:
  - pc = RESET_PC; state RUN.
  - All cache valid bits 0.
  - if_valid = 0, if_insn = 0, if_pc = 0, if_pc4 = 0.
  - mem_req = 0, mem_addr = 0, busy = 0, pend_redirect = 0.
- Address split: IDX_W = log2(LINES). index = pc[IDX_W+1:2], tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is always 0; branch_target[1:0] is forced to 0 when loaded.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W; max address -> 0, no error.
- Lookup is combinational on pc. hit = valid[index] && tag_ram[index]==tag.
- State RUN, priority high to low:
  - pcsrc=1: pc <= target; if_valid <= 0 (flush); overrides id_stall.
  - id_stall=1: pc and all if_* held.
  - hit: if_insn <= data[index], if_pc <= pc, if_pc4 <= pc+4, if_valid <= 1, pc <= pc+4. Throughput 1 instruction/cycle.
  - miss: if_valid <= 0; mem_req <= 1, mem_addr <= pc; go MISS.
- State MISS:
  - mem_req and mem_addr held stable until mem_ack; a request is never abandoned.
  - pcsrc=1 while in MISS: latch target into pend_target, set pend_redirect. A later pcsrc overwrites the latched target.
  - id_stall=1 holds if_* outputs; otherwise if_valid = 0.
  - On mem_ack:
    - Write data, tag and valid bit to the line; mem_req <= 0; go RUN.
    - If pend_redirect (or pcsrc this cycle): pc <= target, pend_redirect cleared.
    - Otherwise pc unchanged; it hits next cycle.
    - Minimum miss penalty = 2 cycles + memory latency.
- cache_inv:
  - In RUN: clears all valid bits at the edge; the lookup that cycle still uses the old contents.
  - In MISS: latched and applied at the mem_ack edge, after the fill, so the filled line is also invalid.
- busy = (state==MISS).
- Reset mid-MISS: returns immediately to reset values, mem_req drops asynchronously. Memory must tolerate a dropped request.
- mem_ack while in RUN: ignored.

Test Plan:
1. Cold start: RESET_PC=0x0, release rstn, ack each request after 3 cycles returning 0x20000000+addr -> mem_req at pc=0; if_valid first 1 with if_pc=0, if_insn=0x20000000, if_pc4=4; subsequent sequential misses each add a bubble.
2. Warm loop: after filling 0x0-0x3C, branch to 0x0 with pcsrc=1 -> one cycle if_valid=0 (flush), then 16 consecutive valid instructions, one per cycle, mem_req stays 0.
3. Stall: id_stall=1 for 4 cycles mid-stream at if_pc=0x10 -> if_pc, if_insn and pc frozen, if_valid stays 1; resumes at 0x14 the cycle after release.
4. Redirect during miss: pcsrc=1 with target 0x103 two cycles into a refill -> mem_addr unchanged until ack, line filled, then fetch from 0x100; first valid if_pc=0x100.
5. Conflict and invalidate: fetch 0x0 then 0x40 (same index, LINES=16) -> second access misses and evicts the line; cache_inv then refetch 0x40 -> miss again.
6. Wrap and reset: pc=0xFFFFFFFC hit -> if_pc4=0, next pc=0; assert rstn low while mem_req=1 -> mem_req=0, pc=RESET_PC in the same cycle.
